// File: rtl/servo_pwm_multi_if.sv
// -----------------------------------------------------------------------------
// servo_pwm_multi_if
//   Bundles the global enable, the valid/ready pulse-width command port and the
//   per-channel servo outputs of servo_pwm_multi.
//
//   Signals
//     en          global enable (low: outputs low, slew frozen, counter at 0)
//     cmd_valid   command present
//     cmd_ready   command accepted when cmd_valid & cmd_ready
//     cmd_ch      target channel index
//     cmd_width   requested pulse width in clock cycles
//     cmd_err     one-cycle pulse after an accepted command with cmd_ch >= CHANNELS
//     pwm_out     servo pulse outputs, one per channel
//     settled     bit i high while current width i equals target width i
//     period_tick one-cycle pulse following the last cycle of each period
//
//   Modports
//     master : steering/direction logic side, drives en and the command fields
//     slave  : the PWM generator, drives ready/err and all servo outputs
// -----------------------------------------------------------------------------
interface servo_pwm_multi_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 16
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                en;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [CH_W-1:0]     cmd_ch;
    logic [CNT_W-1:0]    cmd_width;
    logic                cmd_err;
    logic [CHANNELS-1:0] pwm_out;
    logic [CHANNELS-1:0] settled;
    logic                period_tick;

    modport master (
        output en, cmd_valid, cmd_ch, cmd_width,
        input  cmd_ready, cmd_err, pwm_out, settled, period_tick
    );

    modport slave (
        input  en, cmd_valid, cmd_ch, cmd_width,
        output cmd_ready, cmd_err, pwm_out, settled, period_tick
    );
endinterface

// File: rtl/servo_pwm_multi.sv
// -----------------------------------------------------------------------------
// servo_pwm_multi
//   Multi-channel servo PWM generator for the 10 MHz domain. A single shared
//   period counter drives CHANNELS pulse outputs. Each channel keeps a target
//   width (written over the command port, clamped to [MIN_PULSE, MAX_PULSE])
//   and a current width that moves toward the target by at most SLEW_STEP on
//   each period boundary. Because the current width only changes on the
//   boundary cycle, a pulse is never truncated or stretched mid-period.
//
//   Ports
//     clk_10m  10 MHz system clock
//     rst_n    asynchronous active-low reset
//     bus      servo_pwm_multi_if.slave: en, cmd_valid/cmd_ready/cmd_ch/
//              cmd_width/cmd_err, pwm_out, settled, period_tick
// -----------------------------------------------------------------------------
module servo_pwm_multi #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned PERIOD_CYC = 50000,
    parameter int unsigned MIN_PULSE  = 7215,
    parameter int unsigned MAX_PULSE  = 19425,
    parameter int unsigned INIT_PULSE = 11655,
    parameter int unsigned SLEW_STEP  = 555
) (
    input  logic             clk_10m,
    input  logic             rst_n,
    servo_pwm_multi_if.slave bus
);

    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] INIT_W   = CNT_W'(INIT_PULSE);
    localparam logic [CNT_W-1:0] STEP_W   = CNT_W'(SLEW_STEP);
    localparam logic [CNT_W:0]   STEP_X   = (CNT_W+1)'(SLEW_STEP);
    // One extra bit so that CHANNELS itself (e.g. 16 with a 4-bit index) is representable.
    localparam logic [CH_W:0]    CH_LIM   = (CH_W+1)'(CHANNELS);

    // Parameter legality, rejected at elaboration.
    if (!(CHANNELS >= 1 && CHANNELS <= 16 &&
          MIN_PULSE <= INIT_PULSE && INIT_PULSE <= MAX_PULSE &&
          MAX_PULSE < PERIOD_CYC &&
          longint'(PERIOD_CYC) <= (longint'(1) << CNT_W) &&
          longint'(SLEW_STEP)  <  (longint'(1) << CNT_W))) begin : g_param_check
        $error("servo_pwm_multi: illegal parameter combination");
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] clamp_width(input logic [CNT_W-1:0] w);
        if (w < MIN_W) begin
            return MIN_W;
        end
        if (w > MAX_W) begin
            return MAX_W;
        end
        return w;
    endfunction

    // Move cur toward tgt by at most SLEW_STEP. The comparison is done on
    // CNT_W+1 bits so cur+STEP cannot wrap, and a remaining distance of at most
    // one step snaps exactly onto the target instead of overshooting it.
    function automatic logic [CNT_W-1:0] slew_toward(input logic [CNT_W-1:0] cur,
                                                      input logic [CNT_W-1:0] tgt);
        logic [CNT_W:0] reach;
        reach = '0;
        if (SLEW_STEP == 0) begin
            return tgt;
        end
        if (tgt >= cur) begin
            reach = {1'b0, cur} + STEP_X;
            return (reach >= {1'b0, tgt}) ? tgt : reach[CNT_W-1:0];
        end
        reach = {1'b0, tgt} + STEP_X;
        return (reach >= {1'b0, cur}) ? tgt : (cur - STEP_W);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    tgt_q [CHANNELS];
    logic [CNT_W-1:0]    tgt_d [CHANNELS];
    logic [CNT_W-1:0]    cur_q [CHANNELS];
    logic [CNT_W-1:0]    cur_d [CHANNELS];
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [CHANNELS-1:0] settled_q, settled_d;
    logic                tick_q, tick_d;
    logic                err_q, err_d;

    logic                boundary;
    logic                cmd_ready;
    logic                cmd_fire;
    logic                ch_ok;
    logic [CNT_W-1:0]    width_clamped;

    // The boundary cycle is the only cycle that updates cur; holding ready low
    // there keeps target writes and slew updates in separate cycles.
    assign boundary      = bus.en & (cnt_q == LAST_CNT);
    assign cmd_ready     = rst_n & ~boundary;
    assign cmd_fire      = bus.cmd_valid & cmd_ready;
    assign ch_ok         = ({1'b0, bus.cmd_ch} < CH_LIM);
    assign width_clamped = clamp_width(bus.cmd_width);

    always_comb begin
        cnt_d     = '0;
        pwm_d     = '0;
        settled_d = '0;
        tick_d    = boundary;
        err_d     = cmd_fire & ~ch_ok;

        if (bus.en && !boundary) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        for (int unsigned i = 0; i < CHANNELS; i++) begin
            // Output registered one cycle behind the counter value it reflects.
            pwm_d[i]     = bus.en & (cnt_q < cur_q[i]);
            settled_d[i] = (cur_q[i] == tgt_q[i]);

            cur_d[i] = cur_q[i];
            if (boundary) begin
                cur_d[i] = slew_toward(cur_q[i], tgt_q[i]);
            end

            tgt_d[i] = tgt_q[i];
            if (cmd_fire && ch_ok && (bus.cmd_ch == CH_W'(i))) begin
                tgt_d[i] = width_clamped;
            end
        end
    end

    always_ff @(posedge clk_10m or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pwm_q     <= '0;
            settled_q <= '1;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                tgt_q[i] <= INIT_W;
                cur_q[i] <= INIT_W;
            end
        end else begin
            cnt_q     <= cnt_d;
            pwm_q     <= pwm_d;
            settled_q <= settled_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                tgt_q[i] <= tgt_d[i];
                cur_q[i] <= cur_d[i];
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.cmd_err     = err_q;
    assign bus.pwm_out     = pwm_q;
    assign bus.settled     = settled_q;
    assign bus.period_tick = tick_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_multi
//   Bench for servo_pwm_multi with a shortened period. dut uses 3 channels and
//   a slew step of 25; dut0 uses 8 channels with the slew disabled. Both share
//   clock, reset and enable, so their counters run in lock step.
// -----------------------------------------------------------------------------
module tb_servo_pwm_multi;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned P     = 200;
    localparam int unsigned MINP  = 40;
    localparam int unsigned MAXP  = 150;
    localparam int unsigned INITP = 80;
    localparam int unsigned STEP  = 25;
    localparam int unsigned CH    = 3;
    localparam int unsigned CHW   = 2;
    localparam int unsigned CH0   = 8;
    localparam int unsigned CHW0  = 3;

    logic clk_10m = 1'b0;
    logic rst_n;

    always #5 clk_10m = ~clk_10m;

    servo_pwm_multi_if #(.CHANNELS(CH),  .CNT_W(CNT_W)) bus ();
    servo_pwm_multi_if #(.CHANNELS(CH0), .CNT_W(CNT_W)) bus0 ();

    servo_pwm_multi #(
        .CHANNELS(CH), .CNT_W(CNT_W), .PERIOD_CYC(P), .MIN_PULSE(MINP),
        .MAX_PULSE(MAXP), .INIT_PULSE(INITP), .SLEW_STEP(STEP)
    ) dut (
        .clk_10m(clk_10m), .rst_n(rst_n), .bus(bus.slave)
    );

    servo_pwm_multi #(
        .CHANNELS(CH0), .CNT_W(CNT_W), .PERIOD_CYC(P), .MIN_PULSE(MINP),
        .MAX_PULSE(MAXP), .INIT_PULSE(INITP), .SLEW_STEP(0)
    ) dut0 (
        .clk_10m(clk_10m), .rst_n(rst_n), .bus(bus0.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model of dut: period phase, target and current widths kept
    // as plain integers, updated by the rules of the servo controller.
    // -------------------------------------------------------------------------
    function automatic int clamp_m(input int w);
        if (w < int'(MINP)) return int'(MINP);
        if (w > int'(MAXP)) return int'(MAXP);
        return w;
    endfunction

    function automatic int slew_m(input int c, input int t, input int s);
        int d;
        d = t - c;
        if (s == 0 || (d <= s && d >= -s)) return t;
        return (d > 0) ? c + s : c - s;
    endfunction

    int          m_cnt;
    int          m_tgt [CH];
    int          m_cur [CH];
    logic [CH-1:0] e_pwm, e_set;
    logic        e_tick, e_err;
    logic        m_bnd, m_hs;

    assign m_bnd = bus.en && (m_cnt == int'(P) - 1);
    assign m_hs  = bus.cmd_valid && !m_bnd;

    always @(posedge clk_10m or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            e_pwm  <= '0;
            e_set  <= '1;
            e_tick <= 1'b0;
            e_err  <= 1'b0;
            for (int i = 0; i < int'(CH); i++) begin
                m_tgt[i] <= int'(INITP);
                m_cur[i] <= int'(INITP);
            end
        end else begin
            for (int i = 0; i < int'(CH); i++) begin
                e_pwm[i] <= bus.en && (m_cnt < m_cur[i]);
                e_set[i] <= (m_cur[i] == m_tgt[i]);
                if (m_bnd) m_cur[i] <= slew_m(m_cur[i], m_tgt[i], int'(STEP));
                if (m_hs && int'(bus.cmd_ch) == i) m_tgt[i] <= clamp_m(int'(bus.cmd_width));
            end
            e_tick <= m_bnd;
            e_err  <= m_hs && (int'(bus.cmd_ch) >= int'(CH));
            m_cnt  <= (bus.en && !m_bnd) ? m_cnt + 1 : 0;
        end
    end

    // Per-cycle comparison of every dut output against the model.
    always @(posedge clk_10m) begin
        #1;
        check("pwm_out",     bus.pwm_out,     e_pwm);
        check("settled",     bus.settled,     e_set);
        check("period_tick", bus.period_tick, e_tick);
        check("cmd_err",     bus.cmd_err,     e_err);
        check("cmd_ready",   bus.cmd_ready,   rst_n && !m_bnd);
    end

    // -------------------------------------------------------------------------
    // Measured pulse widths per period and tick intervals.
    // -------------------------------------------------------------------------
    int hc  [CH];
    int hc0 [CH0];
    int wq  [CH][$];
    int wq0 [CH0][$];
    int ival;
    int ti [$];

    always @(posedge clk_10m) begin
        #1;
        for (int i = 0; i < int'(CH); i++) begin
            if (!rst_n || !bus.en) hc[i] = 0;
            else begin
                hc[i] += int'(bus.pwm_out[i]);
                if (bus.period_tick) begin
                    wq[i].push_back(hc[i]);
                    hc[i] = 0;
                end
            end
        end
        for (int i = 0; i < int'(CH0); i++) begin
            if (!rst_n || !bus0.en) hc0[i] = 0;
            else begin
                hc0[i] += int'(bus0.pwm_out[i]);
                if (bus0.period_tick) begin
                    wq0[i].push_back(hc0[i]);
                    hc0[i] = 0;
                end
            end
        end
        if (!rst_n || !bus.en) ival = 0;
        else begin
            ival++;
            if (bus.period_tick) begin
                ti.push_back(ival);
                ival = 0;
            end
        end
    end

    function automatic int w_at(input int ch, input int idx);
        if (idx < wq[ch].size()) return wq[ch][idx];
        return -1;
    endfunction

    function automatic int w0_at(input int ch, input int idx);
        if (idx < wq0[ch].size()) return wq0[ch][idx];
        return -1;
    endfunction

    function automatic int ti_at(input int idx);
        if (idx < ti.size()) return ti[idx];
        return -1;
    endfunction

    task automatic clear_q();
        for (int i = 0; i < int'(CH); i++) wq[i].delete();
        for (int i = 0; i < int'(CH0); i++) wq0[i].delete();
        ti.delete();
    endtask

    // -------------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge)
    // -------------------------------------------------------------------------
    task automatic set_en(input logic v);
        bus.en  = v;
        bus0.en = v;
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            @(negedge clk_10m);
            k++;
        end while (!bus.period_tick && k < int'(P) + 5);
        check("period_tick wait", bus.period_tick, 1);
    endtask

    task automatic wait_cnt(input int v);
        int k;
        k = 0;
        do begin
            @(negedge clk_10m);
            k++;
        end while (m_cnt != v && k < int'(P) + 5);
    endtask

    task automatic send_cmd(input int ch, input int w);
        int k;
        k = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_ch    = CHW'(ch);
        bus.cmd_width = CNT_W'(w);
        while (!bus.cmd_ready && k < int'(P) + 5) begin
            @(negedge clk_10m);
            k++;
        end
        check("cmd_ready wait", bus.cmd_ready, 1);
        @(negedge clk_10m);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_cmd0(input int ch, input int w);
        int k;
        k = 0;
        bus0.cmd_valid = 1'b1;
        bus0.cmd_ch    = CHW0'(ch);
        bus0.cmd_width = CNT_W'(w);
        while (!bus0.cmd_ready && k < int'(P) + 5) begin
            @(negedge clk_10m);
            k++;
        end
        check("dut0 cmd_ready wait", bus0.cmd_ready, 1);
        @(negedge clk_10m);
        bus0.cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        set_en(1'b0);
        bus.cmd_valid  = 1'b0;
        bus.cmd_ch     = '0;
        bus.cmd_width  = '0;
        bus0.cmd_valid = 1'b0;
        bus0.cmd_ch    = '0;
        bus0.cmd_width = '0;

        // Reset state.
        repeat (3) @(negedge clk_10m);
        check("reset pwm_out",     bus.pwm_out, 0);
        check("reset settled",     bus.settled, 32'h7);
        check("reset period_tick", bus.period_tick, 0);
        check("reset cmd_err",     bus.cmd_err, 0);
        check("reset cmd_ready",   bus.cmd_ready, 0);
        check("reset dut0 pwm",    bus0.pwm_out, 0);
        check("reset dut0 settled", bus0.settled, 32'hFF);

        // Free-running: every channel 80 of 200 cycles, tick every 200.
        rst_n = 1'b1;
        set_en(1'b1);
        wait_tick();
        clear_q();
        repeat (2) wait_tick();
        check("idle width ch0",      w_at(0, 0), 80);
        check("idle width ch2",      w_at(2, 1), 80);
        check("idle tick interval",  ti_at(0), 200);
        check("idle dut0 width ch7", w0_at(7, 1), 80);

        // Slew ch1 up to 150: 80 (write period), 105, 130, 150.
        clear_q();
        repeat (10) @(negedge clk_10m);
        send_cmd(1, 150);
        repeat (4) wait_tick();
        check("slew ch1 p0", w_at(1, 0), 80);
        check("slew ch1 p1", w_at(1, 1), 105);
        check("slew ch1 p2", w_at(1, 2), 130);
        check("slew ch1 p3", w_at(1, 3), 150);
        check("slew ch0 untouched", w_at(0, 3), 80);
        repeat (2) @(negedge clk_10m);
        check("settled after slew", bus.settled, 32'h7);

        // Out-of-range channel.
        send_cmd(3, 100);
        check("cmd_err pulse", bus.cmd_err, 1);
        @(negedge clk_10m);
        check("cmd_err one cycle", bus.cmd_err, 0);

        // Clamping, with and without slew.
        wait_tick();
        clear_q();
        repeat (10) @(negedge clk_10m);
        send_cmd(0, 10);
        send_cmd(2, 60000);
        send_cmd0(0, 10);
        send_cmd0(2, 60000);
        repeat (4) wait_tick();
        check("clamp lo slew p1", w_at(0, 1), 55);
        check("clamp lo slew p2", w_at(0, 2), 40);
        check("clamp hi slew p1", w_at(2, 1), 105);
        check("clamp hi slew p3", w_at(2, 3), 150);
        check("dut0 clamp lo p0", w0_at(0, 0), 80);
        check("dut0 clamp lo p1", w0_at(0, 1), 40);
        check("dut0 clamp hi p1", w0_at(2, 1), 150);

        // Command held across the boundary cycle on dut0.
        clear_q();
        wait_cnt(int'(P) - 1);
        bus0.cmd_valid = 1'b1;
        bus0.cmd_ch    = CHW0'(5);
        bus0.cmd_width = CNT_W'(120);
        check("dut0 ready at boundary", bus0.cmd_ready, 0);
        @(negedge clk_10m);
        check("dut0 ready after boundary", bus0.cmd_ready, 1);
        @(negedge clk_10m);
        bus0.cmd_valid = 1'b0;
        repeat (2) wait_tick();
        check("dut0 ch5 p0", w0_at(5, 0), 80);
        check("dut0 ch5 p1", w0_at(5, 1), 80);
        check("dut0 ch5 p2", w0_at(5, 2), 120);

        // Enable dropped mid-pulse, target written while disabled.
        clear_q();
        repeat (5) @(negedge clk_10m);
        send_cmd(1, 40);
        wait_tick();
        check("en test ch1 p0", w_at(1, 0), 150);
        wait_cnt(30);
        check("pwm1 high before en drop", bus.pwm_out[1], 1);
        set_en(1'b0);
        @(posedge clk_10m);
        #1;
        check("pwm low after en drop", bus.pwm_out, 0);
        repeat (20) @(negedge clk_10m);
        send_cmd(2, 100);
        repeat (20) @(negedge clk_10m);
        clear_q();
        set_en(1'b1);
        repeat (3) wait_tick();
        check("restart tick interval", ti_at(0), 200);
        check("frozen slew ch1 p0", w_at(1, 0), 125);
        check("resumed slew ch1 p1", w_at(1, 1), 100);
        check("resumed slew ch1 p2", w_at(1, 2), 75);
        check("disabled write ch2 p0", w_at(2, 0), 150);
        check("disabled write ch2 p2", w_at(2, 2), 100);

        // Asynchronous reset mid-slew, mid-pulse.
        wait_cnt(20);
        check("pwm1 high before reset", bus.pwm_out[1], 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async reset pwm_out",   bus.pwm_out, 0);
        check("async reset settled",   bus.settled, 32'h7);
        check("async reset cmd_ready", bus.cmd_ready, 0);
        check("async reset dut0 pwm",  bus0.pwm_out, 0);
        repeat (3) @(negedge clk_10m);
        rst_n = 1'b1;
        clear_q();
        repeat (2) wait_tick();
        check("post reset ch0", w_at(0, 0), 80);
        check("post reset ch1", w_at(1, 0), 80);
        check("post reset ch2", w_at(2, 1), 80);
        check("post reset dut0 ch2", w0_at(2, 1), 80);
        check("post reset dut0 ch5", w0_at(5, 0), 80);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
